// File: rtl/aes_key_pkg.sv
// Shared AES key-schedule types, constants and helpers.
// Optional feature macro: INV_KEY_MIXCOL_EN enables the InvMixColumns helper
// used to emit equivalent-inverse-cipher round keys.
package aes_key_pkg;

   localparam int AES_NR = 10;

   typedef logic [127:0] key_t;
   typedef logic [31:0]  word_t;

   typedef enum logic {
      IDLE = 1'b0,
      EMIT = 1'b1
   } state_t;

   // Round constants indexed by round number, byte in [31:24]; 11..15 pad the 4-bit index
   localparam word_t RCON [0:15] = '{
      32'h00000000, 32'h01000000, 32'h02000000, 32'h04000000,
      32'h08000000, 32'h10000000, 32'h20000000, 32'h40000000,
      32'h80000000, 32'h1b000000, 32'h36000000, 32'h00000000,
      32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000
   };

   // Forward AES S-box, entry 0 is the leftmost byte
   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] x);
      return SBOX[x];
   endfunction

`ifdef INV_KEY_MIXCOL_EN
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Multiply by one of 9, 11, 13, 14: all contain x^3, low three bits select x^2, x, 1
   function automatic logic [7:0] gmul_inv(input logic [7:0] b, input logic [3:0] c);
      logic [7:0] x2, x4, x8;
      x2 = xtime(b);
      x4 = xtime(x2);
      x8 = xtime(x4);
      return x8 ^ (c[2] ? x4 : 8'h00) ^ (c[1] ? x2 : 8'h00) ^ (c[0] ? b : 8'h00);
   endfunction

   function automatic key_t inv_mix_columns(input key_t k);
      key_t r;
      logic [7:0] s0, s1, s2, s3;
      r = '0;
      for (int c = 0; c < 4; c++) begin
         s0 = k[127-32*c -: 8];
         s1 = k[119-32*c -: 8];
         s2 = k[111-32*c -: 8];
         s3 = k[103-32*c -: 8];
         r[127-32*c -: 8] = gmul_inv(s0, 4'he) ^ gmul_inv(s1, 4'hb) ^ gmul_inv(s2, 4'hd) ^ gmul_inv(s3, 4'h9);
         r[119-32*c -: 8] = gmul_inv(s0, 4'h9) ^ gmul_inv(s1, 4'he) ^ gmul_inv(s2, 4'hb) ^ gmul_inv(s3, 4'hd);
         r[111-32*c -: 8] = gmul_inv(s0, 4'hd) ^ gmul_inv(s1, 4'h9) ^ gmul_inv(s2, 4'he) ^ gmul_inv(s3, 4'hb);
         r[103-32*c -: 8] = gmul_inv(s0, 4'hb) ^ gmul_inv(s1, 4'hd) ^ gmul_inv(s2, 4'h9) ^ gmul_inv(s3, 4'he);
      end
      return r;
   endfunction
`endif

endpackage

// File: rtl/sub_word.sv
// SubWord: forward AES S-box applied to each byte of a 32-bit word.
// Purely combinational; shared with the forward key expander.
module sub_word
   import aes_key_pkg::*;
(
   input  word_t i_word,
   output word_t o_word
);

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_sbox
         assign o_word[8*gi +: 8] = sbox(i_word[8*gi +: 8]);
      end
   endgenerate

endmodule

// File: rtl/inv_key_expander.sv
// AES-128 inverse key schedule: loads the round-10 key and emits round keys
// 10 down to 0, one per valid/ready handshake.
// Optional feature macro: INV_KEY_MIXCOL_EN emits rounds 9..1 as
// InvMixColumns(round key); the key register itself always stays raw.
module inv_key_expander
   import aes_key_pkg::*;
#(
   parameter int NR = AES_NR
)(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [127:0] key_in,
   output logic         busy,
   output logic         key_valid,
   input  logic         key_ready,
   output logic [127:0] key_out,
   output logic [3:0]   key_round,
   output logic         done
);

   localparam logic [3:0] LAST_ROUND = 4'(NR);

   state_t     r_state, w_state_next;
   key_t       r_key, w_key_next;
   logic [3:0] r_round, w_round_next;
   logic       r_done, w_done_next;

   word_t w_a0, w_a1, w_a2, w_a3;
   word_t w_b0, w_b1, w_b2, w_b3;
   word_t w_rot, w_sub;
   key_t  w_prev_key;

   // Backward step from the current key register
   assign w_a0 = r_key[127:96];
   assign w_a1 = r_key[95:64];
   assign w_a2 = r_key[63:32];
   assign w_a3 = r_key[31:0];

   assign w_b3 = w_a3 ^ w_a2;
   assign w_b2 = w_a2 ^ w_a1;
   assign w_b1 = w_a1 ^ w_a0;
   assign w_rot = {w_b3[23:0], w_b3[31:24]};

   sub_word u_sub_word (
      .i_word (w_rot),
      .o_word (w_sub)
   );

   assign w_b0       = w_a0 ^ w_sub ^ RCON[r_round];
   assign w_prev_key = {w_b0, w_b1, w_b2, w_b3};

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_next;
   end

   // Next-state and datapath update selection
   always_comb begin
      w_state_next = r_state;
      w_key_next   = r_key;
      w_round_next = r_round;
      w_done_next  = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_state_next = EMIT;
               w_key_next   = key_in;
               w_round_next = LAST_ROUND;
            end
         end
         EMIT: begin
            if (key_ready) begin
               if (r_round == 4'd0) begin
                  w_state_next = IDLE;
                  w_done_next  = 1'b1;
               end else begin
                  w_key_next   = w_prev_key;
                  w_round_next = r_round - 4'd1;
               end
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   // Key, round and done registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_key   <= '0;
         r_round <= '0;
         r_done  <= 1'b0;
      end else begin
         r_key   <= w_key_next;
         r_round <= w_round_next;
         r_done  <= w_done_next;
      end
   end

   assign busy      = (r_state == EMIT);
   assign key_valid = (r_state == EMIT);
   assign key_round = r_round;
   assign done      = r_done;

`ifdef INV_KEY_MIXCOL_EN
   // Middle rounds leave as equivalent-inverse-cipher keys; first and last stay raw
   assign key_out = (r_round != 4'd0 && r_round != LAST_ROUND) ? inv_mix_columns(r_key) : r_key;
`else
   assign key_out = r_key;
`endif

endmodule
